// File: rtl/chess_render_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chess_render_pkg
// Purpose  : Piece codes, palette and 11x11 piece sprites for the board renderer.
// Revision : 1.0
// ============================================================================
package chess_render_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        KING   = 3'd1,
        QUEEN  = 3'd2,
        BISHOP = 3'd3,
        KNIGHT = 3'd4,
        ROOK   = 3'd5,
        PAWN   = 3'd6
    } piece_t;

    localparam logic [11:0] DARKTILE   = 12'h368;
    localparam logic [11:0] LIGHTTILE  = 12'hEA9;
    localparam logic [11:0] CURSOR     = 12'h0F3;
    localparam logic [11:0] SELECTED   = 12'hF56;
    localparam logic [11:0] LASTMOVE   = 12'hCC4;
    localparam logic [11:0] BLACKPIECE = 12'h113;
    localparam logic [11:0] WHITEPIECE = 12'hEEF;

    // Sprite bit sx*11+sy: each 11-bit group is one column sx, listed sx=10 down to sx=0.
    localparam logic [120:0] SPRITE_KING = {
        11'b11000000000, 11'b11110000000, 11'b11111110000, 11'b11111111000,
        11'b11111111010, 11'b11111111111, 11'b11111111010, 11'b11111111000,
        11'b11111110000, 11'b11110000000, 11'b11000000000};
    localparam logic [120:0] SPRITE_QUEEN = {
        11'b11000000011, 11'b11110000110, 11'b11111101100, 11'b11111111000,
        11'b11111111011, 11'b11111111110, 11'b11111111011, 11'b11111111000,
        11'b11111101100, 11'b11110000110, 11'b11000000011};
    localparam logic [120:0] SPRITE_BISHOP = {
        11'b11000000000, 11'b11100000000, 11'b11110011000, 11'b11111111100,
        11'b11111011110, 11'b11111101111, 11'b11111011110, 11'b11111111100,
        11'b11110011000, 11'b11100000000, 11'b11000000000};
    localparam logic [120:0] SPRITE_KNIGHT = {
        11'b11000000000, 11'b11110000000, 11'b11111000000, 11'b11111110100,
        11'b11111111110, 11'b11111111111, 11'b11111111111, 11'b11111111110,
        11'b11110111100, 11'b11100011000, 11'b11000000000};
    localparam logic [120:0] SPRITE_ROOK = {
        11'b11000000111, 11'b11111111100, 11'b11111111111, 11'b11111111100,
        11'b11111111111, 11'b11111111100, 11'b11111111111, 11'b11111111100,
        11'b11111111111, 11'b11111111100, 11'b11000000111};
    localparam logic [120:0] SPRITE_PAWN = {
        11'b11000000100, 11'b11100000000, 11'b11110011000, 11'b11111111100,
        11'b11111111110, 11'b11111111110, 11'b11111111110, 11'b11111111100,
        11'b11110011000, 11'b11100000000, 11'b11000000100};

endpackage
`default_nettype wire

// File: rtl/chess_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module   : chess_sprite_rom
// Purpose  : Combinational lookup of one sprite bit from (piece code, sx, sy).
// Revision : 1.0
// ============================================================================
module chess_sprite_rom
    import chess_render_pkg::*;
(
    input  logic [2:0] i_code,
    input  logic [3:0] i_sx,
    input  logic [3:0] i_sy,
    output logic       o_pixel
);

    logic [120:0] w_sprite;
    logic [6:0]   w_idx;

    // EMPTY and the unused code 3'b111 both fall to an all-clear sprite.
    always_comb begin
        w_sprite = '0;
        case (i_code)
            KING:    w_sprite = SPRITE_KING;
            QUEEN:   w_sprite = SPRITE_QUEEN;
            BISHOP:  w_sprite = SPRITE_BISHOP;
            KNIGHT:  w_sprite = SPRITE_KNIGHT;
            ROOK:    w_sprite = SPRITE_ROOK;
            PAWN:    w_sprite = SPRITE_PAWN;
            default: w_sprite = '0;
        endcase
    end

    assign w_idx   = 7'(i_sx) * 7'd11 + 7'(i_sy);
    assign o_pixel = (i_sx < 4'd11) && (i_sy < 4'd11) && w_sprite[w_idx];

endmodule
`default_nettype wire

// File: rtl/chess_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : chess_board_renderer
// Purpose  : 3-stage pixel pipeline drawing an 8x8 board from a per-frame snapshot.
// Revision : 1.0
// ============================================================================
module chess_board_renderer
    import chess_render_pkg::*;
#(
    parameter int ORIGIN_X     = 100,
    parameter int ORIGIN_Y     = 40,
    parameter int SQUARE       = 50,
    parameter int SCALE        = 4,
    parameter int BLINK_FRAMES = 30
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         pix_en,
    input  logic [9:0]   pixel_x,
    input  logic [9:0]   pixel_y,
    input  logic         de,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic         frame_start,
    input  logic [255:0] board,
    input  logic [13:0]  move_data,
    input  logic [5:0]   last_from,
    input  logic [5:0]   last_to,
    input  logic         last_valid,
    output logic [3:0]   red,
    output logic [3:0]   green,
    output logic [3:0]   blue,
    output logic         hsync_out,
    output logic         vsync_out
);

    localparam int c_margin = (SQUARE - 11 * SCALE) / 2;
    localparam int c_span   = 11 * SCALE;

    logic [255:0] r_board;
    logic [13:0]  r_move;
    logic [5:0]   r_last_from, r_last_to;
    logic         r_last_valid, r_loaded, r_blink_on;

    // r_loaded keeps the screen black between reset and the first snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_board      <= '0;
            r_move       <= '0;
            r_last_from  <= '0;
            r_last_to    <= '0;
            r_last_valid <= 1'b0;
            r_loaded     <= 1'b0;
        end else if (frame_start) begin
            r_board      <= board;
            r_move       <= move_data;
            r_last_from  <= last_from;
            r_last_to    <= last_to;
            r_last_valid <= last_valid;
            r_loaded     <= 1'b1;
        end
    end

    generate
        if (BLINK_FRAMES > 0) begin : g_blink
            localparam int c_cw = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
            logic [c_cw-1:0] r_frame_cnt;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= 1'b1;
                end else if (frame_start) begin
                    if (r_frame_cnt == c_cw'(BLINK_FRAMES - 1)) begin
                        r_frame_cnt <= '0;
                        r_blink_on  <= ~r_blink_on;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end
            end
        end else begin : g_no_blink
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_blink_on <= 1'b1;
                else       r_blink_on <= 1'b1;
            end
        end
    endgenerate

    // Stage 1: board geometry via compare chains
    logic [2:0] w_col, w_row, w_file, w_rank;
    logic [9:0] w_ox, w_oy;
    logic       w_inboard;

    always_comb begin
        w_col = 3'd0;
        w_row = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(pixel_x) >= ORIGIN_X + i * SQUARE) w_col = 3'(i);
            if (int'(pixel_y) >= ORIGIN_Y + i * SQUARE) w_row = 3'(i);
        end
    end

    assign w_ox      = 10'(int'(pixel_x) - ORIGIN_X - int'(w_col) * SQUARE);
    assign w_oy      = 10'(int'(pixel_y) - ORIGIN_Y - int'(w_row) * SQUARE);
    assign w_inboard = de
                     && (int'(pixel_x) >= ORIGIN_X) && (int'(pixel_x) < ORIGIN_X + 8 * SQUARE)
                     && (int'(pixel_y) >= ORIGIN_Y) && (int'(pixel_y) < ORIGIN_Y + 8 * SQUARE);
    assign w_file    = r_move[13] ? 3'd7 - w_col : w_col;
    assign w_rank    = r_move[13] ? 3'd7 - w_row : w_row;

    logic       r1_in, r1_hs, r1_vs;
    logic [5:0] r1_sq;
    logic [9:0] r1_ox, r1_oy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_in <= 1'b0;
            r1_sq <= '0;
            r1_ox <= '0;
            r1_oy <= '0;
            r1_hs <= 1'b1;
            r1_vs <= 1'b1;
        end else if (pix_en) begin
            r1_in <= w_inboard;
            r1_sq <= {w_file, w_rank};
            r1_ox <= w_ox;
            r1_oy <= w_oy;
            r1_hs <= hsync_in;
            r1_vs <= vsync_in;
        end
    end

    // Stage 2: sprite cell, piece fetch and tile parity
    int         w_dx, w_dy;
    logic [3:0] w_sx, w_sy, w_nibble;
    logic       w_in_sprite, w_sprite_bit;

    always_comb begin
        w_dx = int'(r1_ox) - c_margin;
        w_dy = int'(r1_oy) - c_margin;
        w_in_sprite = (w_dx >= 0) && (w_dx < c_span) && (w_dy >= 0) && (w_dy < c_span);
        w_sx = 4'd0;
        w_sy = 4'd0;
        for (int j = 1; j < 11; j++) begin
            if (w_dx >= j * SCALE) w_sx = 4'(j);
            if (w_dy >= j * SCALE) w_sy = 4'(j);
        end
    end

    assign w_nibble = r_board[{r1_sq, 2'b00} +: 4];

    chess_sprite_rom u_sprite_rom (
        .i_code  (w_nibble[2:0]),
        .i_sx    (w_sx),
        .i_sy    (w_sy),
        .o_pixel (w_sprite_bit)
    );

    logic       r2_in, r2_piece, r2_black, r2_dark, r2_hs, r2_vs;
    logic [5:0] r2_sq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_in    <= 1'b0;
            r2_piece <= 1'b0;
            r2_black <= 1'b0;
            r2_dark  <= 1'b0;
            r2_sq    <= '0;
            r2_hs    <= 1'b1;
            r2_vs    <= 1'b1;
        end else if (pix_en) begin
            r2_in    <= r1_in;
            r2_piece <= w_in_sprite && w_sprite_bit;
            r2_black <= w_nibble[3];
            r2_dark  <= r1_sq[3] ^ r1_sq[0];
            r2_sq    <= r1_sq;
            r2_hs    <= r1_hs;
            r2_vs    <= r1_vs;
        end
    end

    // Stage 3: colour priority
    logic [11:0] w_rgb, r_rgb;

    always_comb begin
        w_rgb = 12'h000;
        if (!r2_in || !r_loaded)
            w_rgb = 12'h000;
        else if (r2_piece)
            w_rgb = r2_black ? BLACKPIECE : WHITEPIECE;
        else if ((r2_sq == r_move[5:0]) && r_blink_on)
            w_rgb = CURSOR;
        else if ((r2_sq == r_move[11:6]) && r_move[12])
            w_rgb = SELECTED;
        else if (r_last_valid && ((r2_sq == r_last_from) || (r2_sq == r_last_to)))
            w_rgb = LASTMOVE;
        else
            w_rgb = r2_dark ? DARKTILE : LIGHTTILE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb     <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else if (pix_en) begin
            r_rgb     <= w_rgb;
            hsync_out <= r2_hs;
            vsync_out <= r2_vs;
        end
    end

    assign red   = r_rgb[11:8];
    assign green = r_rgb[7:4];
    assign blue  = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_chess_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_chess_board_renderer
// Purpose  : Directed bench for the board renderer (blink-off and BLINK_FRAMES=2 builds).
// Revision : 1.0
// ============================================================================
module tb_chess_board_renderer;

    logic         clk = 1'b0;
    logic         reset;
    logic         pix_en;
    logic [9:0]   pixel_x, pixel_y;
    logic         de, hsync_in, vsync_in, frame_start;
    logic [255:0] board;
    logic [13:0]  move_data;
    logic [5:0]   last_from, last_to;
    logic         last_valid;
    logic [3:0]   red, green, blue, red1, green1, blue1;
    logic         hsync_out, vsync_out, hsync_out1, vsync_out1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    chess_board_renderer #(.BLINK_FRAMES(0)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .de(de), .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
        .board(board), .move_data(move_data), .last_from(last_from), .last_to(last_to),
        .last_valid(last_valid), .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    chess_board_renderer #(.BLINK_FRAMES(2)) dut_blink (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .de(de), .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
        .board(board), .move_data(move_data), .last_from(last_from), .last_to(last_to),
        .last_valid(last_valid), .red(red1), .green(green1), .blue(blue1),
        .hsync_out(hsync_out1), .vsync_out(vsync_out1)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 12'h%03h expected 12'h%03h", tag, obs, exp);
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            @(negedge clk) pix_en = 1'b1;
            @(negedge clk) pix_en = 1'b0;
        end
    endtask

    task automatic set_px(input int x, input int y, input logic d);
        @(negedge clk);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        de      = d;
    endtask

    task automatic show(input int x, input int y);
        set_px(x, y, 1'b1);
        strobes(3);
    endtask

    task automatic fs();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; pixel_x = '0; pixel_y = '0; de = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0;
        board = '0; move_data = '0; last_from = '0; last_to = '0; last_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rgb", {red, green, blue}, 12'h000);
        check("reset_hs", {11'b0, hsync_out}, 12'h001);
        check("reset_vs", {11'b0, vsync_out}, 12'h001);
        reset = 1'b0;

        // No snapshot yet: board area stays black
        show(150, 40);
        check("no_snapshot", {red, green, blue}, 12'h000);

        fs();
        show(99, 40);
        check("left_of_board", {red, green, blue}, 12'h000);

        hsync_in = 1'b0;
        set_px(100, 40, 1'b1);
        strobes(2);
        check("latency_2", {red, green, blue}, 12'h000);
        check("hs_latency_2", {11'b0, hsync_out}, 12'h001);
        strobes(1);
        check("cursor_sq0", {red, green, blue}, 12'h0F3);
        check("hs_latency_3", {11'b0, hsync_out}, 12'h000);
        hsync_in = 1'b1;

        show(150, 40);
        check("sq8_dark", {red, green, blue}, 12'h368);
        show(499, 439);
        check("last_px_light", {red, green, blue}, 12'hEA9);
        show(500, 40);
        check("right_of_board", {red, green, blue}, 12'h000);
        set_px(150, 40, 1'b0);
        strobes(3);
        check("de_low", {red, green, blue}, 12'h000);

        // Pawn sprite and snapshot isolation
        board[3:0] = 4'h6;
        fs();
        show(105, 53);
        check("white_pawn", {red, green, blue}, 12'hEEF);
        show(105, 45);
        check("pawn_clear_bit", {red, green, blue}, 12'h0F3);
        board[3:0] = 4'hE;
        show(105, 53);
        check("no_tearing", {red, green, blue}, 12'hEEF);
        fs();
        show(105, 53);
        check("black_pawn", {red, green, blue}, 12'h113);
        board[3:0] = 4'h7;
        fs();
        show(105, 53);
        check("invalid_code", {red, green, blue}, 12'h0F3);

        // Selection and last-move highlights
        board = '0;
        move_data = {1'b0, 1'b1, 6'd9, 6'd20};
        last_from = 6'd10; last_to = 6'd11; last_valid = 1'b1;
        fs();
        show(150, 90);
        check("selected", {red, green, blue}, 12'hF56);
        show(150, 140);
        check("last_from", {red, green, blue}, 12'hCC4);
        show(150, 190);
        check("last_to", {red, green, blue}, 12'hCC4);
        show(100, 40);
        check("light_sq0", {red, green, blue}, 12'hEA9);
        last_valid = 1'b0;
        fs();
        show(150, 140);
        check("last_disabled", {red, green, blue}, 12'h368);
        move_data[5:0] = 6'd9;
        fs();
        show(150, 90);
        check("cursor_over_sel", {red, green, blue}, 12'h0F3);

        // Flipped view
        board[255:252] = 4'h9;
        move_data = {1'b1, 1'b0, 6'd0, 6'd20};
        fs();
        show(123, 63);
        check("flip_king", {red, green, blue}, 12'h113);
        show(473, 413);
        check("flip_far", {red, green, blue}, 12'hEA9);
        move_data[13] = 1'b0;
        fs();
        show(473, 413);
        check("noflip_king", {red, green, blue}, 12'h113);

        // Blink with BLINK_FRAMES=2, cursor on dark square 8
        board = '0;
        move_data = {1'b0, 1'b0, 6'd0, 6'd8};
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        fs(); show(150, 40);
        check("blink_f1", {red1, green1, blue1}, 12'h0F3);
        fs(); show(150, 40);
        check("blink_f2", {red1, green1, blue1}, 12'h368);
        fs(); show(150, 40);
        check("blink_f3", {red1, green1, blue1}, 12'h368);
        fs(); show(150, 40);
        check("blink_f4", {red1, green1, blue1}, 12'h0F3);
        fs(); show(150, 40);
        check("blink_f5", {red1, green1, blue1}, 12'h0F3);
        fs(); show(150, 40);
        check("blink_f6", {red1, green1, blue1}, 12'h368);

        // Asynchronous reset mid-line
        hsync_in = 1'b0; vsync_in = 1'b0;
        show(150, 40);
        check("pre_reset_rgb", {red, green, blue}, 12'h0F3);
        check("pre_reset_vs", {11'b0, vsync_out}, 12'h000);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midline_rgb", {red, green, blue}, 12'h000);
        check("midline_hs", {11'b0, hsync_out}, 12'h001);
        check("midline_vs", {11'b0, vsync_out}, 12'h001);
        @(negedge clk) reset = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        show(150, 40);
        check("post_reset_black", {red, green, blue}, 12'h000);
        fs();
        show(150, 40);
        check("post_reset_frame", {red, green, blue}, 12'h0F3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chess_board_renderer.md
# chess_board_renderer

Parametrised, pipelined chessboard pixel renderer for the VGA output path. Consumes the pixel coordinates and syncs from the VGA timing generator, the packed 64-square board and the move-input state, and emits 12-bit RGB with syncs delayed to match. Successor to the fixed 400x400 painter. Adds configurable geometry and sprite scale, per-frame board snapshot (no tearing), cursor blink, last-move highlight and a flipped (black-side) view.

## Interface
- ORIGIN_X, 100: left edge of the board in pixels.
- ORIGIN_Y, 40: top edge of the board in pixels.
- SQUARE, 50: square edge in pixels; must satisfy SQUARE >= 11*SCALE.
- SCALE, 4: screen pixels per sprite cell, applied in both axes.
- BLINK_FRAMES, 30: frames per cursor blink half-period; 0 disables blinking.
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_en  in  1  25 MHz pixel strobe; the pipeline advances only when this is high.
- pixel_x, pixel_y  in  10 each  current pixel coordinate from the timing generator.
- de  in  1  display enable.
- hsync_in, vsync_in  in  1 each  raw syncs.
- frame_start  in  1  single-clk pulse at the first pixel of vertical blank.
- board  in  256  square s is held in bits [4s+3:4s]. Bit 3 is colour (0 white, 1 black); bits 2:0 are the piece code.
- move_data  in  14  bits [5:0] cursor; [11:6] selected square; [12] selected valid; [13] flip view.
- last_from, last_to  in  6 each  last move squares.
- last_valid  in  1  last-move highlight enable.
- red, green, blue  out  4 each  pixel colour.
- hsync_out, vsync_out  out  1 each  syncs delayed to align with the colour outputs.

## Operation
- **Snapshot.** On frame_start, latch board, move_data, last_from, last_to and last_valid into shadow registers. All rendering uses the shadow copies. If frame_start and pix_en are high together, the latch still occurs; the current pixel uses the old shadow.
- **Blink.** A frame counter increments on each frame_start. At BLINK_FRAMES-1 it wraps to 0 and toggles blink_on. Reset state: counter 0, blink_on 1. With BLINK_FRAMES=0 the counter is held and blink_on stays 1.
- **Stage 1 (geometry).**
  - inboard = de && ORIGIN_X <= x < ORIGIN_X+8*SQUARE && ORIGIN_Y <= y < ORIGIN_Y+8*SQUARE.
  - col = (x-ORIGIN_X)/SQUARE and row = (y-ORIGIN_Y)/SQUARE, computed by a compare chain (no dividers). ox and oy are the remainders.
  - file = flip ? 7-col : col; rank = flip ? 7-row : row; sq = {file, rank}.
- **Stage 2 (lookup).**
  - Sprite margin m = (SQUARE-11*SCALE)/2. sx = (ox-m)/SCALE and sy = (oy-m)/SCALE when 0 <= ox-m < 11*SCALE (same range test on oy); otherwise the pixel is outside the sprite.
  - Fetch the piece nibble for sq. Fetch the sprite bit at index sx*11+sy for that piece code.
  - dark = file[0]^rank[0].
- **Stage 3 (colour), in priority order:**
  1. !de or !inboard: black (12'h000).
  2. Piece code non-empty and sprite bit set: WHITEPIECE or BLACKPIECE, chosen by bit 3.
  3. sq == cursor and blink_on: CURSOR.
  4. sq == selected and selected valid: SELECTED.
  5. last_valid and sq is last_from or last_to: LASTMOVE.
  6. Otherwise DARKTILE or LIGHTTILE.
- **Invalid piece code.** Code 3'b111 renders as an empty square.

## Timing
- Latency is 3 pix_en strobes from pixel_x/pixel_y/de/syncs to the colour outputs. hsync_out and vsync_out go through an identical 3-stage delay.
- All pipeline registers hold their value when pix_en is low.
- Reset values:
  - red, green, blue: 0.
  - hsync_out, vsync_out: 1.
  - Shadow board: all zero (empty board).
  - Shadow move_data and last-move registers: 0.
  - Blink counter: 0; blink_on: 1.
- Reset asserted mid-frame clears everything immediately. Output stays black until the next frame_start loads a snapshot; syncs resume after 3 strobes.

## Structure
- Package chess_render_pkg holds:
  - piece codes (EMPTY=0, KING=1, QUEEN=2, BISHOP=3, KNIGHT=4, ROOK=5, PAWN=6);
  - colour constants DARKTILE=12'h368, LIGHTTILE=12'hEA9, CURSOR=12'h0F3, SELECTED=12'hF56, LASTMOVE=12'hCC4, BLACKPIECE=12'h113, WHITEPIECE=12'hEEF;
  - the six 121-bit sprite constants.
- Sub-module chess_sprite_rom: combinational map from (piece code, sx, sy) to a sprite bit.

## Test plan
- Default params, empty board, cursor at 0, BLINK_FRAMES=0. Pixel (100,40) -> 12'h0F3 after exactly 3 strobes. Pixel (150,40), square 8 -> 12'h368. Pixel (99,40) -> 12'h000.
- White pawn at square 0, sprite cell (0,2) set. Pixel (100+5+0*4, 40+5+2*4) -> 12'hEEF. Same pixel with bit 3=1 -> 12'h113.
- Board input changes mid-frame -> output unchanged until the next frame_start, then reflects the new board.
- flip=1, black king at square 63 -> the king is drawn at screen square col 0, row 0.
- BLINK_FRAMES=2, cursor on an empty dark square -> colour alternates 12'h0F3 / 12'h368 every 2 frames.
- Assert reset mid-line -> red/green/blue read 0 and hsync_out/vsync_out read 1 in the next clk.
